// File: rtl/dff_deser_pkg.sv
// dff_deser_pkg
//   Shared helpers for the serial-to-parallel capture stage.
//   - DEF_W / DEF_CW : default word width and bit-counter width.
//   - is_last_bit()  : true when a bit count marks the final bit of a word.
package dff_deser_pkg;

  localparam int DEF_W  = 4;
  localparam int DEF_CW = 2;

  // The counter is compared against W-1 explicitly so that unreachable
  // counter values (W .. 2**CW-1) never look like a word boundary.
  function automatic logic is_last_bit(input int unsigned cnt, input int unsigned w);
    return (cnt == (w - 1));
  endfunction

endpackage

// File: rtl/dff_rst_cell.sv
// dff_rst_cell
//   Single edge-triggered storage bit with synchronous active-low reset and
//   hold when EN=0. Reset has priority over EN.
//   Ports:
//     C  : clock, rising edge active
//     nR : synchronous reset, active-low
//     EN : load enable
//     D  : data in
//     Q  : registered data out
module dff_rst_cell (
  input  logic C,
  input  logic nR,
  input  logic EN,
  input  logic D,
  output logic Q
);

  always_ff @(posedge C) begin
    if (!nR) begin
      Q <= 1'b0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/dff_deser.sv
// dff_deser
//   Serial-to-parallel capture stage. Collects W consecutive enabled bits
//   from D into a word, presents it on P and pulses V for one cycle.
//   Parameters:
//     W         : word width (>= 2)
//     CW        : bit-counter width, 2**CW >= W
//     MSB_FIRST : 1 = first bit lands in P[W-1], 0 = first bit lands in P[0]
//   Ports:
//     C   : clock, rising edge active
//     nR  : synchronous reset, active-low, priority over EN/D
//     D   : serial data in
//     EN  : shift enable
//     P   : last completed word
//     V   : one-cycle word-valid strobe
//     CNT : bits of the current partial word already captured
module dff_deser
  import dff_deser_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int CW        = DEF_CW,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          C,
  input  logic          nR,
  input  logic          D,
  input  logic          EN,
  output logic [W-1:0]  P,
  output logic          V,
  output logic [CW-1:0] CNT
);

  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next;
  logic [CW-1:0] cnt_next;
  logic          last_bit;
  logic          word_done;

  // Shift direction decides which end the incoming bit enters from; the
  // oldest bit therefore ends up at P[W-1] (MSB first) or P[0] (LSB first).
  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_next = {sr[W-2:0], D};
    end else begin : g_lsb
      assign sr_next = {D, sr[W-1:1]};
    end
  endgenerate

  always_comb begin
    int unsigned cnt_u;
    cnt_u    = 32'(CNT);
    last_bit = is_last_bit(cnt_u, W);
    cnt_next = '0;
    // Anything at or beyond W-1 (including forced unreachable values)
    // returns to 0; only the genuine W-1 count completes a word.
    if (cnt_u < 32'(W - 1)) begin
      cnt_next = CW'(cnt_u + 1);
    end
  end

  assign word_done = EN & last_bit;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_sr
      dff_rst_cell u_sr (.C(C), .nR(nR), .EN(EN), .D(sr_next[gi]), .Q(sr[gi]));
    end

    // P captures sr_next so the bit sampled on the completing edge is included.
    for (gi = 0; gi < W; gi++) begin : g_p
      dff_rst_cell u_p (.C(C), .nR(nR), .EN(word_done), .D(sr_next[gi]), .Q(P[gi]));
    end

    for (gi = 0; gi < CW; gi++) begin : g_cnt
      dff_rst_cell u_cnt (.C(C), .nR(nR), .EN(EN), .D(cnt_next[gi]), .Q(CNT[gi]));
    end
  endgenerate

  // Always enabled: V follows word_done one edge later and clears itself.
  dff_rst_cell u_v (.C(C), .nR(nR), .EN(1'b1), .D(word_done), .Q(V));

endmodule

// File: tb/tb_dff_deser.sv
module tb_dff_deser;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          C = 1'b0;
  logic          nR = 1'b0;
  logic          D = 1'b0;
  logic          EN = 1'b0;
  logic [W-1:0]  p_msb, p_lsb;
  logic          v_msb, v_lsb;
  logic [CW-1:0] cnt_msb, cnt_lsb;

  int checks = 0;
  int errors = 0;

  // Reference state: the bits of the current partial word in arrival order.
  bit           bits_q[$];
  logic [W-1:0] exp_p_msb = '0;
  logic [W-1:0] exp_p_lsb = '0;
  logic         exp_v = 1'b0;
  int           v_count = 0;

  always #5 C = ~C;

  dff_deser #(.W(W), .CW(CW), .MSB_FIRST(1'b1)) u_msb (
    .C(C), .nR(nR), .D(D), .EN(EN), .P(p_msb), .V(v_msb), .CNT(cnt_msb)
  );

  dff_deser #(.W(W), .CW(CW), .MSB_FIRST(1'b0)) u_lsb (
    .C(C), .nR(nR), .D(D), .EN(EN), .P(p_lsb), .V(v_lsb), .CNT(cnt_lsb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: drive inputs away from the edge, advance the model,
  // then compare every output of both instances.
  task automatic step(input logic nr, input logic en, input logic d);
    logic [W-1:0] w_msb, w_lsb;
    @(negedge C);
    nR = nr;
    EN = en;
    D  = d;
    @(posedge C);
    #1;
    exp_v = 1'b0;
    if (!nr) begin
      bits_q.delete();
      exp_p_msb = '0;
      exp_p_lsb = '0;
    end else if (en) begin
      bits_q.push_back(d);
      if (bits_q.size() == W) begin
        w_msb = '0;
        w_lsb = '0;
        for (int i = 0; i < W; i++) begin
          w_msb[W-1-i] = bits_q[i];
          w_lsb[i]     = bits_q[i];
        end
        exp_p_msb = w_msb;
        exp_p_lsb = w_lsb;
        exp_v     = 1'b1;
        bits_q.delete();
      end
    end
    if (v_msb) v_count++;
    check("p_msb",   32'(p_msb),   32'(exp_p_msb));
    check("v_msb",   32'(v_msb),   32'(exp_v));
    check("cnt_msb", 32'(cnt_msb), 32'(bits_q.size()));
    check("p_lsb",   32'(p_lsb),   32'(exp_p_lsb));
    check("v_lsb",   32'(v_lsb),   32'(exp_v));
    check("cnt_lsb", 32'(cnt_lsb), 32'(bits_q.size()));
    $display("step nR=%0b EN=%0b D=%0b | P_msb=%b P_lsb=%b V=%0b CNT=%0d",
             nr, en, d, p_msb, p_lsb, v_msb, cnt_msb);
  endtask

  task automatic send(input logic [3:0] bits4);
    for (int i = 3; i >= 0; i--) step(1'b1, 1'b1, bits4[i]);
  endtask

  initial begin
    // Reset with D=1, EN=1 for two edges.
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("rst_p", 32'(p_msb), 32'h0);

    // First word 1,0,1,1.
    send(4'b1011);
    check("msb_word", 32'(p_msb), 32'hB);
    check("lsb_word", 32'(p_lsb), 32'hD);
    check("word_v",   32'(v_msb), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    check("v_drop",   32'(v_msb), 32'h0);
    check("p_hold",   32'(p_msb), 32'hB);

    // Back-to-back: 1,1,0,0 then 0,1,0,1.
    send(4'b1100);
    check("b2b_1", 32'(p_msb), 32'hC);
    send(4'b0101);
    check("b2b_2", 32'(p_msb), 32'h5);

    // EN gap after two bits; CNT holds at 2.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'(i & 1));
      check("gap_cnt", 32'(cnt_msb), 32'h2);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("gap_word", 32'(p_msb), 32'h9);

    // Reset mid-word after three bits, then a fresh word 0,1,1,0.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("mid_rst_p", 32'(p_msb), 32'h0);
    send(4'b0110);
    check("post_rst", 32'(p_msb), 32'h6);

    // Toggling stream with continuous enable: V every 4 edges.
    v_count = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'(i & 1));
    check("v_rate", 32'(v_count), 32'd4);

    // Randomized traffic with occasional resets and enable gaps.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
